// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access sequencer.
package mem_ctrl_pkg;

  // Sequencer states: wait for an op, run the bus cycle, release, or abort.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

  // Width of the saturating aborted-access counter.
  localparam int unsigned ERR_CNT_W = 8;

  // Load data returned to the pipeline when an access is aborted.
  localparam int unsigned READ_ERR_DATA = 0;

  // Width of the REQ-phase timeout counter (covers TIMEOUT up to 255).
  localparam int unsigned TMO_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == {ERR_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // True when a byte address falls on a 32-bit word boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for the REQ phase. Cleared outside REQ, counts while enabled,
// and flags the last permitted REQ cycle (count == TIMEOUT-1).
module mem_timeout_ctr
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_CNT_W-1:0] LAST_CNT = TMO_CNT_W'(TIMEOUT - 1);
  localparam logic [TMO_CNT_W-1:0] CNT_ONE  = {{(TMO_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_CNT_W-1:0] CNT_ZERO = {TMO_CNT_W{1'b0}};

  logic [TMO_CNT_W-1:0] cnt_q;
  logic [TMO_CNT_W-1:0] cnt_d;

  // Next count: clear has priority; hold at the last value so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous pipeline reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Stalls EX/MEM while a load/store
// runs one req/ack bus transaction, then releases the stall for one cycle.
// Misaligned addresses and bus timeouts turn into a sticky error and a
// zeroed load result instead of hanging the pipeline.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 mem_to_reg_m,
  input  logic                 mem_write_m,
  input  logic [ADDR_W-1:0]    alu_out_m,
  input  logic [DATA_W-1:0]    write_data_m,
  output logic                 stall_m,
  output logic [DATA_W-1:0]    read_data_m,
  output logic                 data_valid,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [DATA_W-1:0]    bus_wdata,
  input  logic                 bus_ack,
  input  logic [DATA_W-1:0]    bus_rdata,
  output logic                 bus_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(READ_ERR_DATA);

  mem_state_t state_q;
  mem_state_t state_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    wdata_d;
  logic                 we_q;
  logic                 we_d;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    rdata_d;
  logic                 dv_q;
  logic                 dv_d;
  logic                 err_q;
  logic                 err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  logic access_s;
  logic aligned_s;
  logic tmo_clear_s;
  logic tmo_en_s;
  logic tmo_expired_s;

  assign access_s  = mem_to_reg_m | mem_write_m;
  assign aligned_s = is_word_aligned(alu_out_m[1:0]);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .clr       (clr),
    .clear_i   (tmo_clear_s),
    .en_i      (tmo_en_s),
    .expired_o (tmo_expired_s)
  );

  // Next-state, bus register loads, error bookkeeping and the stall request.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    dv_d        = 1'b0;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    stall_m     = 1'b0;
    tmo_clear_s = 1'b1;
    tmo_en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (access_s) begin
          // Stall is combinational so the op is frozen in its first cycle.
          stall_m = 1'b1;
          if (aligned_s) begin
            addr_d  = {alu_out_m[ADDR_W-1:2], 2'b00};
            wdata_d = write_data_m;
            we_d    = mem_write_m;  // a load+store combination is a write
            state_d = REQ;
          end else begin
            // Misaligned: abort without touching the bus.
            rdata_d   = ERR_DATA;
            dv_d      = ~mem_write_m;
            err_d     = 1'b1;
            err_cnt_d = err_cnt_sat_inc(err_cnt_q);
            state_d   = ERR;
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        stall_m     = 1'b1;
        tmo_clear_s = 1'b0;
        tmo_en_s    = 1'b1;
        if (bus_ack) begin
          // Ack beats a timeout landing in the same cycle.
          rdata_d = bus_rdata;
          dv_d    = ~we_q;
          state_d = DONE;
        end else if (tmo_expired_s) begin
          rdata_d   = ERR_DATA;
          dv_d      = ~we_q;
          err_d     = 1'b1;
          err_cnt_d = err_cnt_sat_inc(err_cnt_q);
          state_d   = ERR;
        end else begin
          state_d = REQ;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; clr aborts any transaction immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      we_q      <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Bus request is decoded from the state register only, so it follows clr
  // asynchronously and has no path from the pipeline inputs.
  assign bus_req     = (state_q == REQ);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign read_data_m = rdata_q;
  assign data_valid  = dv_q;
  assign bus_err     = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a per-instruction model:
// each op's stall length, bus occupancy, result and error state are derived
// from the access rules, with a bus responder that acks after a chosen wait.
module tb_mem_access_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        clr;
  logic        mem_to_reg_m;
  logic        mem_write_m;
  logic [31:0] alu_out_m;
  logic [31:0] write_data_m;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        data_valid;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [7:0]  err_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model of the sticky error state.
  logic m_err    = 1'b0;
  int   m_errcnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .mem_to_reg_m (mem_to_reg_m),
    .mem_write_m  (mem_write_m),
    .alu_out_m    (alu_out_m),
    .write_data_m (write_data_m),
    .stall_m      (stall_m),
    .read_data_m  (read_data_m),
    .data_valid   (data_valid),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .err_cnt      (err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_abort();
    m_err = 1'b1;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  // Present one instruction to EX/MEM and hold it until the stall releases.
  // waits = number of REQ cycles before the ack (>= TMO means never acked).
  task automatic run_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdata);
    bit          mem;
    bit          dv;
    int          exp_req;
    int          exp_stall;
    logic [31:0] exp_rd;
    int          n_stall = 0;
    int          n_req   = 0;
    int          cyc     = 0;
    bit          done    = 0;

    mem = ld | st;
    if (!mem) begin
      exp_req = 0; exp_stall = 0; dv = 0; exp_rd = 32'h0;
    end else if (addr[1:0] != 2'b00) begin
      exp_req = 0; exp_stall = 1; dv = !st; exp_rd = 32'h0;
      model_abort();
    end else begin
      exp_req   = (waits < TMO) ? waits + 1 : TMO;
      exp_stall = exp_req + 1;
      dv        = !st;
      exp_rd    = (waits < TMO) ? rdata : 32'h0;
      if (waits >= TMO) model_abort();
    end

    while (!done) begin
      @(negedge clk);
      mem_to_reg_m = ld;
      mem_write_m  = st;
      alu_out_m    = addr;
      write_data_m = wdata;
      if (bus_req) begin
        bus_ack   = (n_req == waits);
        bus_rdata = rdata;
      end else begin
        // Stray acks outside a request must be ignored.
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
      #1;
      if (bus_req) begin
        n_req++;
        check_val("bus_addr", bus_addr, addr);
        check_val("bus_we", 32'(bus_we), 32'(st));
        check_val("bus_wdata", bus_wdata, wdata);
      end
      if (stall_m) begin
        n_stall++;
      end else begin
        done = 1;
        check_val("stall_cycles", 32'(n_stall), 32'(exp_stall));
        check_val("req_cycles", 32'(n_req), 32'(exp_req));
        check_val("data_valid", 32'(data_valid), 32'(dv));
        if (dv) check_val("read_data", read_data_m, exp_rd);
        check_val("bus_err", 32'(bus_err), 32'(m_err));
        check_val("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      end
      cyc++;
      if (!done && cyc > 40) begin
        check_val("op_hang", 32'(cyc), 32'd40);
        done = 1;
      end
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_stall"}, 32'(stall_m), 32'd0);
    check_val({pfx, "_req"}, 32'(bus_req), 32'd0);
    check_val({pfx, "_we"}, 32'(bus_we), 32'd0);
    check_val({pfx, "_addr"}, bus_addr, 32'd0);
    check_val({pfx, "_wdata"}, bus_wdata, 32'd0);
    check_val({pfx, "_rdata"}, read_data_m, 32'd0);
    check_val({pfx, "_dv"}, 32'(data_valid), 32'd0);
    check_val({pfx, "_err"}, 32'(bus_err), 32'd0);
    check_val({pfx, "_errcnt"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic random_ops(input int n);
    int          kind;
    int          w;
    logic        ld;
    logic        st;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      ld   = (kind == 1) || (kind == 3);
      st   = (kind >= 2);
      a    = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      w    = $urandom_range(0, 9);
      run_op(ld, st, a, $urandom, w, $urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    clr          = 1'b1;
    mem_to_reg_m = 1'b0;
    mem_write_m  = 1'b0;
    alu_out_m    = 32'h0;
    write_data_m = 32'h0;
    bus_ack      = 1'b0;
    bus_rdata    = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    clr = 1'b0;

    // ALU-only instructions: no stall, no bus activity.
    for (int i = 0; i < 10; i++) run_op(1'b0, 1'b0, $urandom, $urandom, 0, 32'h0);

    // Directed cases.
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D);
    run_op(1'b0, 1'b1, 32'h200, 32'h12345678, 4, 32'h0);
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h0);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, TMO, 32'h55AA55AA);
    run_op(1'b1, 1'b0, 32'h44, 32'h0, TMO - 1, 32'h0BADBEEF);
    run_op(1'b1, 1'b1, 32'h48, 32'hA5A5A5A5, 1, 32'h0);

    random_ops(300);

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++) begin
      a = $urandom;
      if (a[1:0] == 2'b00) a[0] = 1'b1;
      run_op(1'b1, $urandom_range(0, 1) == 1, a, $urandom, 0, 32'h0);
    end
    check_val("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset in the third REQ cycle of a never-acked load.
    @(negedge clk);
    mem_to_reg_m = 1'b1;
    mem_write_m  = 1'b0;
    alu_out_m    = 32'h80;
    bus_ack      = 1'b0;
    #1;
    check_val("clr_idle_stall", 32'(stall_m), 32'd1);
    @(negedge clk);
    #1;
    check_val("clr_req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("clr_req3", 32'(bus_req), 32'd1);
    clr          = 1'b1;
    mem_to_reg_m = 1'b0;
    #1;
    check_reset_vals("clr");
    m_err    = 1'b0;
    m_errcnt = 0;
    @(negedge clk);
    clr = 1'b0;

    random_ops(30);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
